i2s_tx_serializer: RTL and testbench
====================================

// Module: i2s_tx_serializer
// PURPOSE
//  I2S transmitter for the chorus pedal output path. Pulls one processed mono sample per frame
//  from the fast-to-slow CDC FIFO read side. Serializes it MSB-first into both L and R slots.
//  Generates sck/ws/sd for the DAC. Runs entirely in the slow audio domain, clk_i = 2 x bit clock.
// PARAMETERS
//  PKT_WIDTH   16  sample width from CDC FIFO (bits)
//  SLOT_WIDTH  16  bits per channel slot; must be >= PKT_WIDTH; frame = 2*SLOT_WIDTH bits
//  UCNT_WIDTH  8   width of saturating underrun counter
// PORTS
//  clk_i          in   1           audio clock, 2 x sck rate (2.8224 MHz for 44.1 kHz, 16-bit slots)
//  rst_i          in   1           synchronous, active-high reset
//  enable_i       in   1           run enable; low = idle (same state as reset)
//  pkt_i          in   PKT_WIDTH   sample from FIFO, valid when pktValid_i high (first-word fall-through)
//  pktValid_i     in   1           FIFO not empty
//  readEN_o       out  1           one-clk pop strobe to FIFO, once per frame
//  sck_o          out  1           I2S bit clock (clk_i / 2)
//  ws_o           out  1           I2S word select, 0 = left, 1 = right
//  sd_o           out  1           I2S serial data, changes on sck falling edge
//  underrunCnt_o  out  UCNT_WIDTH  saturating count of frames with no sample available
// BEHAVIOUR
//  Reset (rst_i=1, or enable_i=0):
//   - Outputs: sck_o=0, ws_o=0, sd_o=0, readEN_o=0.
//   - State: bitCnt=2*SLOT_WIDTH-2, holdReg=0, shiftReg=0.
//   - underrunCnt_o cleared by rst_i only; enable_i=0 holds it.
//   - Both take effect at the next clk edge, including mid-frame; no partial-frame completion.
//  Clocking:
//   - sckPhase toggles every clk; sck_o = sckPhase.
//   - "Fall event" = a clk cycle with sckPhase==1; all serial state updates only on fall events.
//  Bit counter: 0..2*SLOT_WIDTH-1, +1 per fall event, wraps to 0.
//  Word select, registered on fall events (one-bit-early I2S framing):
//   - next bitCnt in [SLOT_WIDTH-1, 2*SLOT_WIDTH-2] -> ws_o=1; otherwise ws_o=0.
//  Fetch: on the fall event where bitCnt becomes 2*SLOT_WIDTH-1, readEN_o=1 for the next clk only.
//   - In that clk, if pktValid_i=1: holdReg <= pkt_i.
//   - If pktValid_i=0 (underrun): holdReg keeps its old value (last sample repeats), and
//     underrunCnt_o increments, saturating at all-ones.
//  Load: on the fall events where bitCnt becomes 0 and SLOT_WIDTH:
//   - shiftReg <= {holdReg, (SLOT_WIDTH-PKT_WIDTH) zeros}.
//   - L and R carry the identical sample.
//  Shift: on every other fall event, shiftReg shifts left by 1, zero fill.
//  sd_o = shiftReg MSB, registered with the shift/load.
//   - So sd_o changes one clk after sck_o rises and is stable across the sck rising edge.
//  Throughput: exactly one readEN_o pulse per 4*SLOT_WIDTH clk. The FIFO is never popped otherwise.
//  Latency: a sample captured at fetch appears as sd_o MSB 2 clk later (next fall event).
//  First frame after reset/enable:
//   - Fall events occur at clk 1,3,5,... after release.
//   - First readEN_o pulse is at clk 2.
//   - Left MSB is driven after the fall event at clk 3.
//  Simultaneous rst_i and enable_i: rst_i dominates.
//  pktValid_i changing outside the readEN_o clk is ignored.
// TESTING
//  1. Reset/startup:
//     - During rst_i: all outputs 0.
//     - After release: readEN_o pulses at clk 2, then exactly every 64 clk (SLOT_WIDTH=16).
//     - sck_o period = 2 clk.
//  2. Serialization:
//     - pkt_i=16'hA5C3, pktValid_i=1.
//     - sd_o reads 1010_0101_1100_0011 in the left slot, identical in the right slot.
//     - ws_o rises one sck before the right MSB and falls one sck before the next left MSB.
//  3. Underrun:
//     - Frame 1 with 16'h1234 valid, frame 2 with pktValid_i=0.
//     - Frame 2 repeats 16'h1234 in both slots; underrunCnt_o goes 0 -> 1.
//  4. Saturation: 300 consecutive underrun frames -> underrunCnt_o = 8'hFF, stays there.
//  5. enable_i dropped mid-left-slot:
//     - Next clk: sck_o/ws_o/sd_o/readEN_o = 0.
//     - On re-enable: fresh frame, first readEN_o at clk 2, underrunCnt_o unchanged.
//  6. rst_i asserted mid-frame with underrunCnt_o=5:
//     - Next clk: all outputs 0, underrunCnt_o=0.
//     - Next frame sends holdReg=0 if the FIFO is empty at the first fetch.

Source files
------------

// File: rtl/i2s_tx_serializer_if.sv
// FIFO read-side handshake between the CDC FIFO (master) and the I2S serializer (slave).
// First-word fall-through: pkt is valid whenever pktValid is high; readEN pops one word.
interface i2s_tx_serializer_if #(
    parameter int unsigned PKT_WIDTH = 16
);
    logic [PKT_WIDTH-1:0] pkt;
    logic                 pktValid;
    logic                 readEN;

    modport master (output pkt, output pktValid, input readEN);
    modport slave  (input pkt, input pktValid, output readEN);
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: one mono sample per frame from the FIFO, sent MSB-first in both L and R slots.
// clk_i runs at twice the bit clock; serial state only advances on the cycles where sck is high.
module i2s_tx_serializer #(
    parameter int unsigned PKT_WIDTH  = 16,
    parameter int unsigned SLOT_WIDTH = 16,
    parameter int unsigned UCNT_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    i2s_tx_serializer_if.slave    fifo_if,
    output logic                  sck_o,
    output logic                  ws_o,
    output logic                  sd_o,
    output logic [UCNT_WIDTH-1:0] underrunCnt_o
);
    localparam int unsigned FRAME = 2 * SLOT_WIDTH;
    localparam int unsigned CNT_W = $clog2(FRAME);
    localparam int unsigned PAD   = SLOT_WIDTH - PKT_WIDTH;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME - 1);
    localparam logic [CNT_W-1:0] CNT_IDLE  = CNT_W'(FRAME - 2);
    localparam logic [CNT_W-1:0] CNT_SLOT  = CNT_W'(SLOT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_WS_LO = CNT_W'(SLOT_WIDTH - 1);

    logic                  sckPhase_q, sckPhase_d;
    logic [CNT_W-1:0]      bitCnt_q,   bitCnt_d;
    logic                  ws_q,       ws_d;
    logic                  readEN_q,   readEN_d;
    logic [PKT_WIDTH-1:0]  hold_q,     hold_d;
    logic [SLOT_WIDTH-1:0] shift_q,    shift_d;
    logic [UCNT_WIDTH-1:0] ucnt_q,     ucnt_d;
    logic [CNT_W-1:0]      bitCntNext;

    always_comb begin
        sckPhase_d = ~sckPhase_q;
        bitCnt_d   = bitCnt_q;
        ws_d       = ws_q;
        readEN_d   = 1'b0;
        hold_d     = hold_q;
        shift_d    = shift_q;
        ucnt_d     = ucnt_q;
        bitCntNext = (bitCnt_q == CNT_LAST) ? '0 : bitCnt_q + 1'b1;

        // The pop strobe is always in a low-sck cycle, so capture never collides with a load.
        if (readEN_q) begin
            if (fifo_if.pktValid) begin
                hold_d = fifo_if.pkt;
            end else if (ucnt_q != '1) begin
                ucnt_d = ucnt_q + 1'b1;
            end
        end

        if (sckPhase_q) begin
            bitCnt_d = bitCntNext;
            ws_d     = (bitCntNext >= CNT_WS_LO) && (bitCntNext <= CNT_IDLE);
            readEN_d = (bitCntNext == CNT_LAST);
            if ((bitCntNext == '0) || (bitCntNext == CNT_SLOT)) begin
                shift_d = SLOT_WIDTH'(hold_q) << PAD;
            end else begin
                shift_d = {shift_q[SLOT_WIDTH-2:0], 1'b0};
            end
        end

        // Disabled looks exactly like reset, except the underrun count is kept.
        if (!enable_i) begin
            sckPhase_d = 1'b0;
            bitCnt_d   = CNT_IDLE;
            ws_d       = 1'b0;
            readEN_d   = 1'b0;
            hold_d     = '0;
            shift_d    = '0;
            ucnt_d     = ucnt_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sckPhase_q <= 1'b0;
            bitCnt_q   <= CNT_IDLE;
            ws_q       <= 1'b0;
            readEN_q   <= 1'b0;
            hold_q     <= '0;
            shift_q    <= '0;
            ucnt_q     <= '0;
        end else begin
            sckPhase_q <= sckPhase_d;
            bitCnt_q   <= bitCnt_d;
            ws_q       <= ws_d;
            readEN_q   <= readEN_d;
            hold_q     <= hold_d;
            shift_q    <= shift_d;
            ucnt_q     <= ucnt_d;
        end
    end

    assign sck_o          = sckPhase_q;
    assign ws_o           = ws_q;
    assign sd_o           = shift_q[SLOT_WIDTH-1];
    assign fifo_if.readEN = readEN_q;
    assign underrunCnt_o  = ucnt_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: startup timing, serialization, underrun,
// counter saturation, enable drop and mid-frame reset.
module tb_i2s_tx_serializer;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       sck, ws, sd;
    logic [7:0] ucnt;

    int unsigned nChecks = 0;
    int unsigned nPass   = 0;

    i2s_tx_serializer_if #(.PKT_WIDTH(16)) fifo_if ();

    i2s_tx_serializer #(
        .PKT_WIDTH (16),
        .SLOT_WIDTH(16),
        .UCNT_WIDTH(8)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .fifo_if      (fifo_if),
        .sck_o        (sck),
        .ws_o         (ws),
        .sd_o         (sd),
        .underrunCnt_o(ucnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".sck"}, {31'd0, sck}, 32'd0);
        check({tag, ".ws"},  {31'd0, ws},  32'd0);
        check({tag, ".sd"},  {31'd0, sd},  32'd0);
        check({tag, ".ren"}, {31'd0, fifo_if.readEN}, 32'd0);
    endtask

    // Entered just after the edge that raised readEN; leaves at the next readEN edge, 64 clk later.
    task automatic check_frame(input string tag, input logic [15:0] expWord);
        logic [15:0] left, right;
        logic [31:0] wsv;
        int unsigned sckErr, renErr;
        logic        renEnd;
        left = '0; right = '0; wsv = '0; sckErr = 0; renErr = 0; renEnd = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (sck !== 1'b1) sckErr++;
            if (fifo_if.readEN !== 1'b0) renErr++;
            tick();
            if (sck !== 1'b0) sckErr++;
            if (k == 31) renEnd = fifo_if.readEN;
            else if (fifo_if.readEN !== 1'b0) renErr++;
            if (k < 16) left[15-k] = sd;
            else        right[31-k] = sd;
            wsv[k] = ws;
        end
        check({tag, ".left"},   {16'd0, left},  {16'd0, expWord});
        check({tag, ".right"},  {16'd0, right}, {16'd0, expWord});
        check({tag, ".ws"},     wsv, 32'h7FFF_8000);
        check({tag, ".sckErr"}, sckErr, 32'd0);
        check({tag, ".renErr"}, renErr, 32'd0);
        check({tag, ".renEnd"}, {31'd0, renEnd}, 32'd1);
    endtask

    initial begin
        int unsigned renMiss;

        // 1. reset and startup
        rst = 1'b1; enable = 1'b1;
        fifo_if.pkt = 16'hA5C3; fifo_if.pktValid = 1'b1;
        tick(3);
        check_idle("rst");
        check("rst.ucnt", {24'd0, ucnt}, 32'd0);
        rst = 1'b0;
        tick();
        check("clk1.sck", {31'd0, sck}, 32'd1);
        check("clk1.ren", {31'd0, fifo_if.readEN}, 32'd0);
        tick();
        check("clk2.sck", {31'd0, sck}, 32'd0);
        check("clk2.ren", {31'd0, fifo_if.readEN}, 32'd1);

        // 2. serialization of A5C3; next frame's fetch gets 1234
        check_frame("a5c3", 16'hA5C3);
        fifo_if.pkt = 16'h1234;
        check_frame("f1234", 16'h1234);
        check("urun.before", {24'd0, ucnt}, 32'd0);

        // 3. underrun repeats the held sample
        fifo_if.pktValid = 1'b0; fifo_if.pkt = 16'hFFFF;
        check_frame("urun", 16'h1234);
        check("urun.after", {24'd0, ucnt}, 32'd1);

        // 4. saturation over 300 underrun frames
        renMiss = 0;
        for (int i = 1; i <= 300; i++) begin
            tick(64);
            if (fifo_if.readEN !== 1'b1) renMiss++;
            if (i == 100) check("sat.mid", {24'd0, ucnt}, 32'h65);
        end
        check("sat.renMiss", renMiss, 32'd0);
        check("sat.ucnt", {24'd0, ucnt}, 32'hFF);

        // 5. enable dropped mid-left-slot
        fifo_if.pktValid = 1'b1; fifo_if.pkt = 16'h0F0F;
        tick(10);
        check("en.sdBefore", {31'd0, sd}, 32'd1);
        enable = 1'b0;
        tick();
        check_idle("en.off");
        tick(5);
        check_idle("en.hold");
        check("en.ucnt", {24'd0, ucnt}, 32'hFF);
        fifo_if.pkt = 16'h8001;
        enable = 1'b1;
        tick();
        check("en.clk1.ren", {31'd0, fifo_if.readEN}, 32'd0);
        tick();
        check("en.clk2.ren", {31'd0, fifo_if.readEN}, 32'd1);
        check_frame("en.f8001", 16'h8001);
        check("en.ucntAfter", {24'd0, ucnt}, 32'hFF);

        // 6. reset mid-frame with five underruns counted
        rst = 1'b1;
        fifo_if.pkt = 16'hFFFF; fifo_if.pktValid = 1'b1;
        tick();
        rst = 1'b0;
        tick(2);
        check("r6.clk2.ren", {31'd0, fifo_if.readEN}, 32'd1);
        tick();
        fifo_if.pktValid = 1'b0;
        tick(63);
        tick(64 * 5);
        check("r6.renAt5", {31'd0, fifo_if.readEN}, 32'd1);
        fifo_if.pktValid = 1'b1;
        tick(5);
        check("r6.ucnt5", {24'd0, ucnt}, 32'd5);
        check("r6.sdBefore", {31'd0, sd}, 32'd1);
        rst = 1'b1;
        tick();
        check_idle("r6.rst");
        check("r6.ucntClr", {24'd0, ucnt}, 32'd0);
        rst = 1'b0;
        fifo_if.pktValid = 1'b0;
        tick(2);
        check("r6.relRen", {31'd0, fifo_if.readEN}, 32'd1);
        check_frame("r6.zero", 16'h0000);
        check("r6.ucnt1", {24'd0, ucnt}, 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
